// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - multi-channel CSR-mapped periodic/one-shot timer
//
// Purpose: NumChannels independent timers, each with a 2^prescaler clock
// divider, a counter that wraps at counter_top, and a mode (off, periodic,
// one-shot). Every expiry raises a registered one-cycle irq_pulse and sets a
// sticky irq_pending bit.
//
// Ports:
//   clk          core clock
//   reset        synchronous, active-high reset
//   csr_we       CSR write strobe, one write per asserted cycle
//   csr_addr     CSR address (12 bits)
//   csr_wdata    CSR write data (32 bits)
//   csr_rdata    CSR read data, combinational from csr_addr, 0 when unmapped
//   irq_pulse    one-cycle expiry pulse per channel
//   irq_pending  sticky pending bits, write-1-to-clear through PEND
//
// Address map (offset from CsrBase):
//   0x00+ch  CFG  {mode[1:0], counter_top, prescaler}
//   0x10+ch  CNT  current counter, read-only
//   0x20     PEND irq_pending, write-1-to-clear
module timer_multi #(
  parameter int          NumChannels   = 4,
  parameter int          TimerWidth    = 16,
  parameter int          TimerPreWidth = 4,
  parameter logic [11:0] CsrBase       = 12'h400
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   csr_we,
  input  logic [11:0]            csr_addr,
  input  logic [31:0]            csr_wdata,
  output logic [31:0]            csr_rdata,
  output logic [NumChannels-1:0] irq_pulse,
  output logic [NumChannels-1:0] irq_pending
);

  // The prescale counter must reach 2^(2^TimerPreWidth - 1) - 1.
  localparam int PreCntWidth = 2 ** TimerPreWidth;
  localparam int TopLsb      = TimerPreWidth;
  localparam int ModeLsb     = TimerPreWidth + TimerWidth;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONE_SHOT = 2'b10,
    MODE_RESERVED = 2'b11   // behaves as off
  } mode_e;

  logic [TimerPreWidth-1:0] prescaler_q [NumChannels];
  logic [TimerWidth-1:0]    top_q       [NumChannels];
  mode_e                    mode_q      [NumChannels];
  logic [PreCntWidth-1:0]   pre_cnt_q   [NumChannels];
  logic [TimerWidth-1:0]    cnt_q       [NumChannels];

  logic [11:0]            offset;
  logic                   pend_wr;
  logic [NumChannels-1:0] pend_clr;
  logic [NumChannels-1:0] cfg_wr;
  logic [NumChannels-1:0] running;
  logic [NumChannels-1:0] tick;
  logic [NumChannels-1:0] expire;

  // Addresses below CsrBase wrap to large offsets and decode as unmapped.
  assign offset   = csr_addr - CsrBase;
  assign pend_wr  = csr_we && (offset == 12'h020);
  assign pend_clr = pend_wr ? csr_wdata[NumChannels-1:0] : '0;

  always_comb begin
    cfg_wr  = '0;
    running = '0;
    tick    = '0;
    expire  = '0;
    for (int ch = 0; ch < NumChannels; ch++) begin
      cfg_wr[ch]  = csr_we && (offset == 12'(ch));
      running[ch] = (mode_q[ch] == MODE_PERIODIC) || (mode_q[ch] == MODE_ONE_SHOT);
      tick[ch]    = running[ch] &&
                    (pre_cnt_q[ch] == ((PreCntWidth'(1) << prescaler_q[ch]) - PreCntWidth'(1)));
      // A CFG write in the expiry cycle restarts the channel and suppresses the expiry.
      expire[ch]  = tick[ch] && (cnt_q[ch] == top_q[ch]) && !cfg_wr[ch];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NumChannels; ch++) begin
        prescaler_q[ch] <= '0;
        top_q[ch]       <= '0;
        mode_q[ch]      <= MODE_OFF;
        pre_cnt_q[ch]   <= '0;
        cnt_q[ch]       <= '0;
      end
      irq_pulse   <= '0;
      irq_pending <= '0;
    end else begin
      for (int ch = 0; ch < NumChannels; ch++) begin
        if (cfg_wr[ch]) begin
          prescaler_q[ch] <= csr_wdata[TimerPreWidth-1:0];
          top_q[ch]       <= csr_wdata[ModeLsb-1:TopLsb];
          mode_q[ch]      <= mode_e'(csr_wdata[ModeLsb+1:ModeLsb]);
          pre_cnt_q[ch]   <= '0;
          cnt_q[ch]       <= '0;
        end else if (tick[ch]) begin
          pre_cnt_q[ch] <= '0;
          if (cnt_q[ch] == top_q[ch]) begin
            cnt_q[ch] <= '0;
            if (mode_q[ch] == MODE_ONE_SHOT) begin
              mode_q[ch] <= MODE_OFF;
            end
          end else begin
            cnt_q[ch] <= cnt_q[ch] + TimerWidth'(1);
          end
        end else if (running[ch]) begin
          pre_cnt_q[ch] <= pre_cnt_q[ch] + PreCntWidth'(1);
        end
      end
      irq_pulse   <= expire;
      // Set has priority over a simultaneous write-1-to-clear.
      irq_pending <= (irq_pending & ~pend_clr) | expire;
    end
  end

  always_comb begin
    csr_rdata = '0;
    for (int ch = 0; ch < NumChannels; ch++) begin
      if (offset == 12'(ch)) begin
        csr_rdata = 32'({mode_q[ch], top_q[ch], prescaler_q[ch]});
      end
      if (offset == 12'(16 + ch)) begin
        csr_rdata = 32'(cnt_q[ch]);
      end
    end
    if (offset == 12'h020) begin
      csr_rdata = 32'(irq_pending);
    end
  end

endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - directed self-checking bench for timer_multi
module tb_timer_multi;

  logic        clk;
  logic        reset;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [3:0]  irq_pulse;
  logic [3:0]  irq_pending;

  int n_checks = 0;
  int n_fail   = 0;

  timer_multi #(
    .NumChannels  (4),
    .TimerWidth   (16),
    .TimerPreWidth(4),
    .CsrBase      (12'h400)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .csr_we     (csr_we),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .irq_pulse  (irq_pulse),
    .irq_pending(irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    @(negedge clk);
    csr_we    = 1'b0;
    csr_wdata = '0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    reset     = 1'b1;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      csr_read(12'h400 + 12'(ch), rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_cfg%0d: got %h expected %h", ch, rd, 32'h0);
      end
      csr_read(12'h410 + 12'(ch), rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_cnt%0d: got %h expected %h", ch, rd, 32'h0);
      end
    end
    csr_read(12'h420, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pend: got %h expected %h", rd, 32'h0);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (irq_pulse !== 4'b0 || irq_pending !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: pulse %b pending %b expected 0000 0000", k, irq_pulse, irq_pending);
      end
    end
  endtask

  task automatic test_periodic;
    logic [31:0] rd;
    logic [3:0]  exp;
    // prescaler 0, top 4, periodic: pulse every 5 cycles
    csr_write(12'h400, 32'h0010_0040);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp = (k % 5 == 0) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (irq_pulse !== exp) begin
        n_fail++;
        $display("FAIL periodic_pulse k=%0d: got %b expected %b", k, irq_pulse, exp);
      end
    end
    csr_write(12'h400, 32'h0);
    csr_read(12'h420, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++;
      $display("FAIL periodic_pend: got %h expected %h", rd, 32'h1);
    end
    csr_write(12'h420, 32'h1);
    csr_read(12'h420, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL periodic_w1c: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_one_shot;
    logic [31:0] rd;
    logic [3:0]  exp;
    int          pulses;
    // prescaler 2, top 2, one-shot: single pulse 12 cycles after write
    csr_write(12'h401, 32'h0020_0022);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp = (k == 12) ? 4'b0010 : 4'b0000;
      n_checks++;
      if (irq_pulse !== exp) begin
        n_fail++;
        $display("FAIL oneshot_pulse k=%0d: got %b expected %b", k, irq_pulse, exp);
      end
    end
    csr_read(12'h401, rd);
    n_checks++;
    if (rd !== 32'h22) begin
      n_fail++;
      $display("FAIL oneshot_cfg: got %h expected %h", rd, 32'h22);
    end
    csr_read(12'h411, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL oneshot_cnt: got %h expected %h", rd, 32'h0);
    end
    csr_read(12'h420, rd);
    n_checks++;
    if (rd !== 32'h2) begin
      n_fail++;
      $display("FAIL oneshot_pend: got %h expected %h", rd, 32'h2);
    end
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (irq_pulse !== 4'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL oneshot_quiet: got %0d pulses expected 0", pulses);
    end
    csr_write(12'h420, 32'h2);
    csr_read(12'h420, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL oneshot_w1c: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_rewrite_on_expiry;
    logic [31:0] rd;
    logic [3:0]  exp;
    // prescaler 0, top 3, periodic: expiry decided on the 4th edge after the write
    csr_write(12'h402, 32'h0010_0030);
    repeat (3) @(negedge clk);
    csr_write(12'h402, 32'h0010_0030);
    n_checks++;
    if (irq_pulse !== 4'b0) begin
      n_fail++;
      $display("FAIL rewrite_no_pulse: got %b expected %b", irq_pulse, 4'b0);
    end
    csr_read(12'h420, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL rewrite_no_pend: got %h expected %h", rd, 32'h0);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp = (k == 4) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (irq_pulse !== exp) begin
        n_fail++;
        $display("FAIL rewrite_next_pulse k=%0d: got %b expected %b", k, irq_pulse, exp);
      end
    end
    csr_write(12'h402, 32'h0);
    csr_write(12'h420, 32'h4);
    csr_read(12'h420, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL rewrite_w1c: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] rd;
    // ch0 and ch3 top 1, prescaler 0, started two cycles apart so they align
    csr_write(12'h400, 32'h0010_0010);
    @(negedge clk);
    csr_write(12'h403, 32'h0010_0010);
    n_checks++;
    if (irq_pulse !== 4'b0001) begin
      n_fail++;
      $display("FAIL simul_first: got %b expected %b", irq_pulse, 4'b0001);
    end
    @(negedge clk);
    csr_write(12'h420, 32'h9);
    n_checks++;
    if (irq_pulse !== 4'b1001) begin
      n_fail++;
      $display("FAIL simul_pulse: got %b expected %b", irq_pulse, 4'b1001);
    end
    csr_read(12'h420, rd);
    n_checks++;
    if (rd !== 32'h9) begin
      n_fail++;
      $display("FAIL simul_set_wins: got %h expected %h", rd, 32'h9);
    end
    csr_write(12'h400, 32'h0);
    csr_write(12'h403, 32'h0);
    csr_write(12'h420, 32'h9);
    csr_read(12'h420, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL simul_w1c: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_reset_mid_count;
    logic [31:0] rd;
    int          pulses;
    // prescaler 0, top 100, periodic
    csr_write(12'h400, 32'h0010_0640);
    repeat (37) @(negedge clk);
    csr_read(12'h410, rd);
    n_checks++;
    if (rd !== 32'd37) begin
      n_fail++;
      $display("FAIL midreset_cnt_before: got %0d expected %0d", rd, 37);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    csr_read(12'h410, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_cnt_after: got %h expected %h", rd, 32'h0);
    end
    csr_read(12'h400, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_cfg_after: got %h expected %h", rd, 32'h0);
    end
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (irq_pulse !== 4'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: got %0d pulses expected 0", pulses);
    end
    csr_write(12'h410, 32'hFFFF_FFFF);
    csr_read(12'h410, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL cnt_write_ignored: got %h expected %h", rd, 32'h0);
    end
    csr_read(12'h400, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL cnt_write_cfg0: got %h expected %h", rd, 32'h0);
    end
    // Unmapped writes inside and outside the block must not start any channel.
    csr_write(12'h404, 32'h0010_0010);
    csr_write(12'h3FF, 32'h0010_0010);
    csr_write(12'h430, 32'h0010_0010);
    csr_read(12'h404, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_read: got %h expected %h", rd, 32'h0);
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (irq_pulse !== 4'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL unmapped_quiet: got %0d pulses expected 0", pulses);
    end
  endtask

  initial begin
    test_reset;
    test_periodic;
    test_one_shot;
    test_rewrite_on_expiry;
    test_simultaneous;
    test_reset_mid_count;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Multi-channel generalisation of the single CSR-mapped peripheral timer.
- Each of NumChannels channels has its own prescaler, counter_top and mode (off / periodic / one-shot), plus an interrupt pulse and a sticky pending bit.
- The core reaches it over the CSR bus; irq_pulse feeds the N-CLIC interrupt sources.

Parameters:
- NumChannels, 4, number of independent timer channels (1..16).
- TimerWidth, 16, counter and counter_top width in bits.
- TimerPreWidth, 4, prescaler field width; division is 2^prescaler, up to 2^(2^TimerPreWidth - 1).
- CsrBase, 'h400, base CSR address of the block.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- csr_we  in  1  CSR write strobe; one write per asserted cycle.
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  CSR write data.
- csr_rdata  out  32  CSR read data, combinational from csr_addr; 0 when csr_addr is unmapped.
- irq_pulse  out  NumChannels  one-cycle expiry pulse per channel.
- irq_pending  out  NumChannels  sticky pending bits.

Behaviour:
- Address map (ch = 0..NumChannels-1):
  - CsrBase+ch, CFG, R/W: [TimerPreWidth-1:0] prescaler; [TimerPreWidth+TimerWidth-1:TimerPreWidth] counter_top; [TimerPreWidth+TimerWidth+1:TimerPreWidth+TimerWidth] mode (00 off, 01 periodic, 10 one-shot, 11 treated as off). Other bits read 0.
  - CsrBase+'h10+ch, CNT, RO: current counter, zero-extended. Writes are ignored.
  - CsrBase+'h20, PEND: read gives irq_pending; write-1-to-clear on bits [NumChannels-1:0].
- Reset: all CFG = 0 (mode off), prescale counters = 0, counters = 0, irq_pulse = 0, irq_pending = 0.
- Per channel, when mode is periodic or one-shot:
  - The prescale counter pre_cnt has 2^TimerPreWidth bits. Tick when pre_cnt == 2^prescaler - 1, then pre_cnt <= 0; otherwise pre_cnt increments.
  - On a tick: if cnt == counter_top, then cnt <= 0, irq_pulse[ch] is asserted the next cycle (registered), and irq_pending[ch] is set. Otherwise cnt increments.
  - Period = (counter_top+1) * 2^prescaler cycles. The first expiry comes that many cycles after the CFG write.
  - One-shot: on expiry the hardware clears mode to 00; cnt and pre_cnt stay at 0.
- Mode off: pre_cnt and cnt hold; no ticks.
- CFG write to a channel: fields take effect the next cycle; pre_cnt and cnt of that channel clear to 0.
- Edge cases:
  - counter_top = 0: expiry on every tick.
  - prescaler = 0: tick every cycle.
  - CFG write in the same cycle as that channel's expiry: the write wins. No pulse, no pending set, counters cleared.
  - PEND W1C in the same cycle as an expiry on the same bit: set wins, and the bit stays 1. Other bits clear normally.
  - Writes to unmapped addresses inside or outside the block range: no effect.
- Channels are fully independent; any number may expire in the same cycle.
- Reset asserted mid-count returns every channel to reset state in the following cycle. No pulse is emitted during or right after reset.

Test Plan:
- Reset, read every CFG/CNT/PEND -> all 0; irq_pulse = 0 for 20 cycles.
- Ch0 CFG prescaler=0, top=4, periodic -> irq_pulse[0] high 1 cycle every 5 cycles, 4 pulses in 20 cycles. PEND reads 1; W1C 'b1 -> 0.
- Ch1 prescaler=2, top=2, one-shot -> single pulse 12 cycles after the write. CFG mode then reads 00 and CNT reads 0; no further pulses over 100 cycles.
- Ch2 periodic top=3, prescaler=0; rewrite CFG on the expiry cycle -> no pulse that cycle, PEND[2] = 0, next pulse 4 cycles after the rewrite.
- Ch0 and ch3 both top=1, prescaler=0, periodic, with PEND W1C of 'b1001 on their common expiry cycle -> PEND stays 'b1001. irq_pulse shows 'b1001 simultaneously.
- Ch0 running top=100; assert reset at CNT=37 -> next cycle CNT=0 and CFG=0; no pulse for 200 cycles. A write to CsrBase+'h10 is ignored.
